rom_burst_reader: RTL

//  Sits directly upstream of the 8x4 lookup ROM: it drives the ROM address bus and

---
 rtl/rom_burst_pkg.sv | 22 ++
 rtl/rom_addr_wrap.sv | 29 ++
 rtl/rom_burst_reader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rom_burst_pkg.sv
// Shared constants, FSM state type and burst-length decode for the ROM burst reader.
package rom_burst_pkg;

  localparam int ADDR_W = 8;   // ROM address bus width
  localparam int DATA_W = 4;   // ROM word width
  localparam int DEPTH  = 8;   // populated ROM words, addresses 0..DEPTH-1
  localparam int LEN_W  = 4;   // burst-length field width
  localparam int SUM_W  = 8;   // running checksum width
  localparam int CNT_W  = LEN_W + 1;  // word counter must hold 2**LEN_W

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // A length field of zero stands for the longest burst, 2**LEN_W words.
  function automatic logic [CNT_W-1:0] burst_words(input logic [LEN_W-1:0] len);
    return (len == '0) ? CNT_W'(1 << LEN_W) : CNT_W'(len);
  endfunction

endpackage

// File: rtl/rom_addr_wrap.sv
// ROM read pointer: loads a start address, then steps through 0..DEPTH-1 and wraps.
module rom_addr_wrap
  import rom_burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;

  // Pointer register: load wins over increment; increment wraps at the last ROM word.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_addr;
    end else if (i_en) begin
      r_ptr <= (r_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rom_burst_reader.sv
// Accepts one (address, length) burst request, reads consecutive ROM words with
// wrap-around and streams them out with last/error flags and a running checksum.
module rom_burst_reader
  import rom_burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_err,
  output logic [SUM_W-1:0]  out_sum,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_remaining;
  logic [ADDR_W-1:0] w_ptr;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_out_err;
  logic [SUM_W-1:0]  r_sum;

  logic              w_accept;
  logic              w_run_load;
  logic              w_err_load;
  logic              w_req_ready;
  logic              w_busy;
  logic [ADDR_W-1:0] w_rom_addr;
  logic              w_out_free;
  logic              w_beat_done;

  // Output register may take a new word when it is empty or being drained this cycle.
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_beat_done = r_out_valid && out_ready;

  rom_addr_wrap u_addr_wrap (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_addr (req_addr),
    .i_en        (w_run_load),
    .o_ptr       (w_ptr)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode; the ROM address is only driven while reading.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_busy      = 1'b1;
    w_rom_addr  = '0;
    w_accept    = 1'b0;
    w_run_load  = 1'b0;
    w_err_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (req_addr >= ADDR_W'(DEPTH)) ? ERR : RUN;
        end
      end
      RUN: begin
        w_rom_addr = w_ptr;
        w_run_load = w_out_free && (r_remaining != '0);
        if (w_beat_done && r_out_last) begin
          w_state_nxt = IDLE;
        end
      end
      ERR: begin
        w_err_load = !r_out_valid;
        if (w_beat_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Words still to be read in the current burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
    end else if (w_accept) begin
      r_remaining <= burst_words(req_len);
    end else if (w_run_load) begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  // Output beat register and checksum; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
      r_sum       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
      r_sum       <= '0;
    end else if (w_run_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= rom_data;
      r_out_last  <= (r_remaining == CNT_W'(1));
      r_out_err   <= 1'b0;
      r_sum       <= r_sum + SUM_W'(rom_data);
    end else if (w_err_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= '0;
      r_out_last  <= 1'b1;
      r_out_err   <= 1'b1;
      r_sum       <= '0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign req_ready = w_req_ready;
  assign busy      = w_busy;
  assign rom_addr  = w_rom_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_err   = r_out_err;
  assign out_sum   = r_sum;

endmodule
